axi4lite_reg_slave: RTL and testbench

AXI4-Lite responder terminating the AXI4-Lite master port of the AXI4-to-AXI4-Lite bridge. Implements an array of `num_regs` data-width registers with byte-strobed writes, in-range/out-of-range decode, and independent read and write channel FSMs. It is the endpoint the bridge's converted single-beat transactions land on, and the bench target for the bridge.

---
 rtl/axi4lite_pkg.sv | 27 ++
 rtl/axi4lite_reg_slave.sv | 201 ++++++++++++++++++++
 tb/tb_axi4lite_reg_slave.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and the
// byte-strobe merge used when committing a write beat into a register.
package axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_NEED_DATA,
      W_NEED_ADDR,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } rd_state_t;

   // Width-independent strobe merge: callers loop over byte lanes.
   function automatic logic [7:0] strb_merge(input logic [7:0] cur,
                                             input logic [7:0] upd,
                                             input logic       en);
      return en ? upd : cur;
   endfunction

endpackage

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register-file responder: num_regs data-width registers, byte
// strobes, range-checked decode, independent write and read channel FSMs.
module axi4lite_reg_slave
   import axi4lite_pkg::*;
#(
   parameter int axi4_addr_size = 32,
   parameter int axi4_data_size = 64,
   parameter int num_regs       = 16
) (
   input  logic                               clk,
   input  logic                               rst,

   output logic                               s_axi4lite_aw_ready,
   input  logic                               s_axi4lite_aw_valid,
   input  logic [axi4_addr_size-1:0]          s_axi4lite_aw_addr,
   input  logic [2:0]                         s_axi4lite_aw_prot,

   output logic                               s_axi4lite_w_ready,
   input  logic                               s_axi4lite_w_valid,
   input  logic [axi4_data_size-1:0]          s_axi4lite_w_data,
   input  logic [(axi4_data_size>>3)-1:0]     s_axi4lite_w_strb,

   input  logic                               s_axi4lite_b_ready,
   output logic                               s_axi4lite_b_valid,
   output logic [1:0]                         s_axi4lite_b_resp,

   output logic                               s_axi4lite_ar_ready,
   input  logic                               s_axi4lite_ar_valid,
   input  logic [axi4_addr_size-1:0]          s_axi4lite_ar_addr,
   input  logic [2:0]                         s_axi4lite_ar_prot,

   input  logic                               s_axi4lite_r_ready,
   output logic                               s_axi4lite_r_valid,
   output logic [axi4_data_size-1:0]          s_axi4lite_r_data,
   output logic [1:0]                         s_axi4lite_r_resp,

   output logic [num_regs*axi4_data_size-1:0] regs_out,
   output logic [num_regs-1:0]                reg_wr_pulse
);

   localparam int STRB_W = axi4_data_size >> 3;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(num_regs);
   localparam int DEC_W  = OFF_W + IDX_W;

   logic [num_regs-1:0][axi4_data_size-1:0] regs;

   assign regs_out = regs;

   // prot carries no meaning for a plain register file
   logic unused_prot;
   assign unused_prot = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot};

   // ---------------------------------------------------------------- write
   wr_state_t                   w_state, w_next;
   logic [axi4_addr_size-1:0]   w_addr_q;
   logic [axi4_data_size-1:0]   w_data_q;
   logic [STRB_W-1:0]           w_strb_q;

   logic                        aw_hs, w_hs, commit;
   logic [axi4_addr_size-1:0]   cm_addr;
   logic [axi4_data_size-1:0]   cm_data;
   logic [STRB_W-1:0]           cm_strb;
   logic [IDX_W-1:0]            cm_idx;
   logic                        cm_in_range;

   always_comb begin
      w_next              = w_state;
      s_axi4lite_aw_ready = 1'b0;
      s_axi4lite_w_ready  = 1'b0;
      s_axi4lite_b_valid  = 1'b0;
      commit              = 1'b0;
      cm_addr             = w_addr_q;
      cm_data             = w_data_q;
      cm_strb             = w_strb_q;
      aw_hs               = 1'b0;
      w_hs                = 1'b0;
      case (w_state)
         W_IDLE: begin
            s_axi4lite_aw_ready = ~rst;
            s_axi4lite_w_ready  = ~rst;
            aw_hs = s_axi4lite_aw_valid & ~rst;
            w_hs  = s_axi4lite_w_valid & ~rst;
            if (aw_hs && w_hs) begin
               commit  = 1'b1;
               cm_addr = s_axi4lite_aw_addr;
               cm_data = s_axi4lite_w_data;
               cm_strb = s_axi4lite_w_strb;
               w_next  = W_RESP;
            end else if (aw_hs) begin
               w_next = W_NEED_DATA;
            end else if (w_hs) begin
               w_next = W_NEED_ADDR;
            end
         end
         W_NEED_DATA: begin
            s_axi4lite_w_ready = ~rst;
            w_hs = s_axi4lite_w_valid & ~rst;
            if (w_hs) begin
               commit  = 1'b1;
               cm_data = s_axi4lite_w_data;
               cm_strb = s_axi4lite_w_strb;
               w_next  = W_RESP;
            end
         end
         W_NEED_ADDR: begin
            s_axi4lite_aw_ready = ~rst;
            aw_hs = s_axi4lite_aw_valid & ~rst;
            if (aw_hs) begin
               commit  = 1'b1;
               cm_addr = s_axi4lite_aw_addr;
               w_next  = W_RESP;
            end
         end
         W_RESP: begin
            s_axi4lite_b_valid = ~rst;
            if (s_axi4lite_b_ready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign cm_idx      = cm_addr[OFF_W +: IDX_W];
   assign cm_in_range = (cm_addr >> DEC_W) == '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state           <= W_IDLE;
         w_addr_q          <= '0;
         w_data_q          <= '0;
         w_strb_q          <= '0;
         regs              <= '0;
         reg_wr_pulse      <= '0;
         s_axi4lite_b_resp <= RESP_OKAY;
      end else begin
         w_state      <= w_next;
         reg_wr_pulse <= '0;
         if (aw_hs) w_addr_q <= s_axi4lite_aw_addr;
         if (w_hs) begin
            w_data_q <= s_axi4lite_w_data;
            w_strb_q <= s_axi4lite_w_strb;
         end
         if (commit) begin
            s_axi4lite_b_resp <= cm_in_range ? RESP_OKAY : RESP_SLVERR;
            if (cm_in_range) begin
               // an all-zero strobe still counts as a committed write
               reg_wr_pulse[cm_idx] <= 1'b1;
               for (int k = 0; k < STRB_W; k++)
                  regs[cm_idx][k*8 +: 8] <= strb_merge(regs[cm_idx][k*8 +: 8],
                                                       cm_data[k*8 +: 8],
                                                       cm_strb[k]);
            end
         end
      end
   end

   // ----------------------------------------------------------------- read
   rd_state_t        r_state, r_next;
   logic             ar_hs;
   logic [IDX_W-1:0] ar_idx;
   logic             ar_in_range;

   always_comb begin
      r_next              = r_state;
      s_axi4lite_ar_ready = 1'b0;
      s_axi4lite_r_valid  = 1'b0;
      ar_hs               = 1'b0;
      case (r_state)
         R_IDLE: begin
            s_axi4lite_ar_ready = ~rst;
            ar_hs = s_axi4lite_ar_valid & ~rst;
            if (ar_hs) r_next = R_RESP;
         end
         R_RESP: begin
            s_axi4lite_r_valid = ~rst;
            if (s_axi4lite_r_ready) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign ar_idx      = s_axi4lite_ar_addr[OFF_W +: IDX_W];
   assign ar_in_range = (s_axi4lite_ar_addr >> DEC_W) == '0;

   // regs sampled before any same-edge commit lands, so a colliding read
   // returns the pre-write value
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state           <= R_IDLE;
         s_axi4lite_r_data <= '0;
         s_axi4lite_r_resp <= RESP_OKAY;
      end else begin
         r_state <= r_next;
         if (ar_hs) begin
            s_axi4lite_r_data <= ar_in_range ? regs[ar_idx] : '0;
            s_axi4lite_r_resp <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave with hand-computed expected values.
module tb_axi4lite_reg_slave;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int NR = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              aw_ready, aw_valid;
   logic [AW-1:0]     aw_addr;
   logic [2:0]        aw_prot;
   logic              w_ready, w_valid;
   logic [DW-1:0]     w_data;
   logic [DW/8-1:0]   w_strb;
   logic              b_ready, b_valid;
   logic [1:0]        b_resp;
   logic              ar_ready, ar_valid;
   logic [AW-1:0]     ar_addr;
   logic [2:0]        ar_prot;
   logic              r_ready, r_valid;
   logic [DW-1:0]     r_data;
   logic [1:0]        r_resp;
   logic [NR*DW-1:0]  regs_out;
   logic [NR-1:0]     reg_wr_pulse;

   logic [DW-1:0]     exp_regs [NR];
   int                n_vec = 0;
   int                n_bad = 0;

   always #5 clk = ~clk;

   axi4lite_reg_slave #(
      .axi4_addr_size(AW), .axi4_data_size(DW), .num_regs(NR)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axi4lite_aw_ready(aw_ready), .s_axi4lite_aw_valid(aw_valid),
      .s_axi4lite_aw_addr(aw_addr), .s_axi4lite_aw_prot(aw_prot),
      .s_axi4lite_w_ready(w_ready), .s_axi4lite_w_valid(w_valid),
      .s_axi4lite_w_data(w_data), .s_axi4lite_w_strb(w_strb),
      .s_axi4lite_b_ready(b_ready), .s_axi4lite_b_valid(b_valid),
      .s_axi4lite_b_resp(b_resp),
      .s_axi4lite_ar_ready(ar_ready), .s_axi4lite_ar_valid(ar_valid),
      .s_axi4lite_ar_addr(ar_addr), .s_axi4lite_ar_prot(ar_prot),
      .s_axi4lite_r_ready(r_ready), .s_axi4lite_r_valid(r_valid),
      .s_axi4lite_r_data(r_data), .s_axi4lite_r_resp(r_resp),
      .regs_out(regs_out), .reg_wr_pulse(reg_wr_pulse)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_regs(input string tag);
      for (int i = 0; i < NR; i++)
         chk($sformatf("%s reg%0d", tag, i), regs_out[i*DW +: DW], exp_regs[i]);
   endtask

   // same-cycle AW+W, b_ready held high: two cycles per write
   task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s, input logic [1:0] er, input logic [NR-1:0] ep);
      aw_valid = 1'b1; aw_addr = a; w_valid = 1'b1; w_data = d; w_strb = s; b_ready = 1'b1;
      step();
      aw_valid = 1'b0; w_valid = 1'b0;
      chk({tag, " bvalid"}, 64'(b_valid), 64'd1);
      chk({tag, " bresp"}, 64'(b_resp), 64'(er));
      chk({tag, " pulse"}, 64'(reg_wr_pulse), 64'(ep));
      step();
      chk({tag, " bdone"}, 64'(b_valid), 64'd0);
   endtask

   task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] ed,
                          input logic [1:0] er);
      ar_valid = 1'b1; ar_addr = a; r_ready = 1'b1;
      step();
      ar_valid = 1'b0;
      chk({tag, " rvalid"}, 64'(r_valid), 64'd1);
      chk({tag, " rdata"}, r_data, ed);
      chk({tag, " rresp"}, 64'(r_resp), 64'(er));
      step();
      chk({tag, " rdone"}, 64'(r_valid), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      aw_valid = 0; aw_addr = '0; aw_prot = '0;
      w_valid = 0; w_data = '0; w_strb = '0; b_ready = 0;
      ar_valid = 0; ar_addr = '0; ar_prot = '0; r_ready = 0;
      for (int i = 0; i < NR; i++) exp_regs[i] = '0;

      // reset state
      step(); step();
      chk("rst aw_ready", 64'(aw_ready), 0);
      chk("rst w_ready", 64'(w_ready), 0);
      chk("rst ar_ready", 64'(ar_ready), 0);
      chk("rst b_valid", 64'(b_valid), 0);
      chk("rst r_valid", 64'(r_valid), 0);
      chk("rst r_data", r_data, 0);
      chk("rst pulse", 64'(reg_wr_pulse), 0);
      chk_regs("rst");
      rst = 1'b0;
      #1;
      chk("post-rst aw_ready", 64'(aw_ready), 1);
      chk("post-rst ar_ready", 64'(ar_ready), 1);

      // same-cycle AW+W, B held off one cycle to see the pulse clear
      aw_valid = 1; aw_addr = 32'h08; w_valid = 1; w_data = 64'h1122334455667788; w_strb = 8'hFF;
      step();
      aw_valid = 0; w_valid = 0;
      exp_regs[1] = 64'h1122334455667788;
      chk("t1 bvalid", 64'(b_valid), 1);
      chk("t1 bresp", 64'(b_resp), 0);
      chk("t1 pulse", 64'(reg_wr_pulse), 64'h0002);
      chk("t1 aw_ready busy", 64'(aw_ready), 0);
      chk_regs("t1");
      b_ready = 1;
      step();
      chk("t1 pulse clear", 64'(reg_wr_pulse), 0);
      chk("t1 bdone", 64'(b_valid), 0);
      do_read("t1 rd", 32'h08, 64'h1122334455667788, 2'b00);

      // AW three cycles ahead of W, partial strobe
      do_write("t2 pre", 32'h10, 64'h0123456789ABCDEF, 8'hFF, 2'b00, 16'h0004);
      aw_valid = 1; aw_addr = 32'h10; b_ready = 1;
      step();
      aw_valid = 0;
      for (int i = 0; i < 3; i++) begin
         chk("t2 aw_ready wait", 64'(aw_ready), 0);
         chk("t2 w_ready wait", 64'(w_ready), 1);
         if (i < 2) step();
      end
      w_valid = 1; w_data = 64'hAAAA; w_strb = 8'h03;
      step();
      w_valid = 0;
      chk("t2 bvalid", 64'(b_valid), 1);
      step();
      exp_regs[2] = 64'h0123456789ABAAAA;
      chk_regs("t2");

      // W before AW on reg5
      do_write("t2b pre", 32'h28, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b00, 16'h0020);
      w_valid = 1; w_data = 64'hAAAA; w_strb = 8'h03;
      step();
      w_valid = 0;
      chk("t2b aw_ready", 64'(aw_ready), 1);
      chk("t2b w_ready", 64'(w_ready), 0);
      step();
      aw_valid = 1; aw_addr = 32'h28;
      step();
      aw_valid = 0;
      chk("t2b bvalid", 64'(b_valid), 1);
      chk("t2b pulse", 64'(reg_wr_pulse), 64'h0020);
      step();
      exp_regs[5] = 64'hFFFFFFFFFFFFAAAA;
      chk_regs("t2b");

      // out of range
      do_write("t3 oor", 32'h80, 64'hDEADBEEFDEADBEEF, 8'hFF, 2'b10, 16'h0000);
      chk_regs("t3");
      do_read("t3 oor rd", 32'h80, 64'h0, 2'b10);
      do_write("t3 zero strb", 32'h08, 64'hFFFF, 8'h00, 2'b00, 16'h0002);
      chk_regs("t3 zs");

      // B backpressure
      aw_valid = 1; aw_addr = 32'h30; w_valid = 1; w_data = 64'hCAFE; w_strb = 8'hFF; b_ready = 0;
      step();
      aw_valid = 0; w_valid = 0;
      for (int i = 0; i < 5; i++) begin
         chk("t4 bvalid hold", 64'(b_valid), 1);
         chk("t4 bresp hold", 64'(b_resp), 0);
         chk("t4 aw_ready hold", 64'(aw_ready), 0);
         chk("t4 w_ready hold", 64'(w_ready), 0);
         step();
      end
      b_ready = 1;
      step();
      chk("t4 bdone", 64'(b_valid), 0);
      exp_regs[6] = 64'hCAFE;

      // R backpressure
      ar_valid = 1; ar_addr = 32'h30; r_ready = 0;
      step();
      ar_valid = 0;
      for (int i = 0; i < 5; i++) begin
         chk("t4 rvalid hold", 64'(r_valid), 1);
         chk("t4 rdata hold", r_data, 64'hCAFE);
         chk("t4 ar_ready hold", 64'(ar_ready), 0);
         step();
      end
      r_ready = 1;
      step();
      chk("t4 rdone", 64'(r_valid), 0);

      // read/write collision on reg3
      ar_valid = 1; ar_addr = 32'h18; r_ready = 1;
      aw_valid = 1; aw_addr = 32'h18; w_valid = 1; w_data = 64'h5; w_strb = 8'hFF; b_ready = 1;
      step();
      ar_valid = 0; aw_valid = 0; w_valid = 0;
      chk("t5 rvalid", 64'(r_valid), 1);
      chk("t5 old data", r_data, 64'h0);
      chk("t5 bvalid", 64'(b_valid), 1);
      step();
      exp_regs[3] = 64'h5;
      do_read("t5 new", 32'h18, 64'h5, 2'b00);

      // reset while waiting for W
      aw_valid = 1; aw_addr = 32'h08;
      step();
      aw_valid = 0;
      chk("t6 in need_data", 64'(aw_ready), 0);
      rst = 1;
      #1;
      chk("t6 rst w_ready", 64'(w_ready), 0);
      chk("t6 rst ar_ready", 64'(ar_ready), 0);
      step();
      for (int i = 0; i < NR; i++) exp_regs[i] = '0;
      chk_regs("t6");
      chk("t6 rst aw_ready", 64'(aw_ready), 0);
      rst = 0;
      #1;
      chk("t6 aw_ready after", 64'(aw_ready), 1);
      chk("t6 w_ready after", 64'(w_ready), 1);
      chk("t6 ar_ready after", 64'(ar_ready), 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6 no bvalid", 64'(b_valid), 0);
      end
      chk_regs("t6 quiet");
      do_write("t6 wr", 32'h00, 64'h77, 8'h01, 2'b00, 16'h0001);
      do_read("t6 rd", 32'h00, 64'h77, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
